// File: rtl/alarm_snooze_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_snooze_ctrl
//
// Ringing/snooze sequencer that sits directly after the alarm clock core.
// It takes the core's Alarm level and drives a beeping buzzer. It also handles
// the user's stop and snooze buttons. It drives the core's STOP_al input, and
// holds it high long enough that the alarm cannot retrigger in the matched
// minute. A ring that is never answered times out and sets a sticky missed
// flag. Snoozes per alarm event are limited.
//
// Optional feature: define ALARM_ESCALATE_EN to enable volume escalation.
//   The volume starts at level 0 on every RING entry and rises one step every
//   ESC_STEP cycles, saturating at 3. At level 3 the buzzer stays on
//   continuously. Without the macro, level is 3 for the whole RING and the
//   buzzer always toggles.
//
// Parameters
//   RING_SEC    cycles RING lasts before auto-timeout        (2..255)
//   SNOOZE_SEC  cycles SNOOZE lasts before re-ring           (2..255)
//   HOLD_SEC    cycles HOLD keeps stop_al high after dismiss (1..255)
//   MAX_SNOOZE  snoozes allowed per alarm event              (1..7)
//   ESC_STEP    cycles per volume step, escalation only      (1..255)
//
// Ports
//   clk_1s        in   1  1 Hz tick; all logic runs on its rising edge
//   reset         in   1  asynchronous, active-high
//   alarm_in      in   1  Alarm level from the clock core
//   stop_btn      in   1  synchronised, level-sampled dismiss request
//   snooze_btn    in   1  synchronised, level-sampled snooze request
//   buzzer        out  1  beep drive
//   stop_al       out  1  to core STOP_al; high in SNOOZE and HOLD
//   snoozing      out  1  high while in SNOOZE
//   snooze_left   out  8  remaining SNOOZE cycles, 0 outside SNOOZE
//   snooze_count  out  3  snoozes taken in the current alarm event
//   missed        out  1  sticky ring-timeout flag
//   level         out  2  buzzer volume
// -----------------------------------------------------------------------------
module alarm_snooze_ctrl #(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 120,
    parameter int HOLD_SEC   = 60,
    parameter int MAX_SNOOZE = 3,
    parameter int ESC_STEP   = 5
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       buzzer,
    output logic       stop_al,
    output logic       snoozing,
    output logic [7:0] snooze_left,
    output logic [2:0] snooze_count,
    output logic       missed,
    output logic [1:0] level
);

    // Elaboration-time guard against out-of-range parameters.
    if (RING_SEC < 2 || RING_SEC > 255) begin : g_bad_ring
        $error("alarm_snooze_ctrl: RING_SEC out of range");
    end
    if (SNOOZE_SEC < 2 || SNOOZE_SEC > 255) begin : g_bad_snooze
        $error("alarm_snooze_ctrl: SNOOZE_SEC out of range");
    end
    if (HOLD_SEC < 1 || HOLD_SEC > 255) begin : g_bad_hold
        $error("alarm_snooze_ctrl: HOLD_SEC out of range");
    end
    if (MAX_SNOOZE < 1 || MAX_SNOOZE > 7) begin : g_bad_max
        $error("alarm_snooze_ctrl: MAX_SNOOZE out of range");
    end
    if (ESC_STEP < 1 || ESC_STEP > 255) begin : g_bad_esc
        $error("alarm_snooze_ctrl: ESC_STEP out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_SEC - 1);
    localparam logic [7:0] SNOOZE_LEN  = 8'(SNOOZE_SEC);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    state_t     state_q;
    logic       buzzer_q;
    logic       stop_al_q;
    logic       snoozing_q;
    logic [7:0] snooze_left_q;
    logic [2:0] snooze_count_q;
    logic       missed_q;
    logic [1:0] level_q;
    logic [7:0] ring_timer_q;
    logic [7:0] hold_timer_q;

    // Transition decisions for the current cycle; the register block below
    // applies the matching entry values.
    logic       enter_ring_d;
    logic       enter_hold_d;
    logic       enter_snooze_d;
    logic       set_missed_d;

    // Buzzer and volume values for a cycle that stays in RING.
    logic       ring_buzz_d;
    logic [1:0] ring_level_d;

`ifdef ALARM_ESCALATE_EN
    localparam logic [7:0] ESC_LAST       = 8'(ESC_STEP - 1);
    localparam logic [1:0] RING_ENTRY_LVL = 2'd0;

    logic [7:0] esc_timer_q;

    always_comb begin
        ring_level_d = level_q;
        if (esc_timer_q == ESC_LAST && level_q != 2'd3) begin
            ring_level_d = level_q + 2'd1;
        end
        // Full volume means a continuous tone rather than a beep.
        ring_buzz_d = (ring_level_d == 2'd3) ? 1'b1 : ~buzzer_q;
    end
`else
    localparam logic [1:0] RING_ENTRY_LVL = 2'd3;

    always_comb begin
        ring_level_d = 2'd3;
        ring_buzz_d  = ~buzzer_q;
    end
`endif

    always_comb begin
        enter_ring_d   = 1'b0;
        enter_hold_d   = 1'b0;
        enter_snooze_d = 1'b0;
        set_missed_d   = 1'b0;
        case (state_q)
            IDLE: begin
                enter_ring_d = alarm_in;
            end
            RING: begin
                // stop wins over snooze; a snooze past the limit acts as stop.
                if (stop_btn) begin
                    enter_hold_d = 1'b1;
                end else if (snooze_btn) begin
                    if (snooze_count_q < SNOOZE_MAX) begin
                        enter_snooze_d = 1'b1;
                    end else begin
                        enter_hold_d = 1'b1;
                    end
                end else if (ring_timer_q == RING_LAST) begin
                    enter_hold_d = 1'b1;
                    set_missed_d = 1'b1;
                end
            end
            SNOOZE: begin
                if (stop_btn) begin
                    enter_hold_d = 1'b1;
                end else if (snooze_left_q == 8'd1) begin
                    enter_ring_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            buzzer_q       <= 1'b0;
            stop_al_q      <= 1'b0;
            snoozing_q     <= 1'b0;
            snooze_left_q  <= 8'd0;
            snooze_count_q <= 3'd0;
            missed_q       <= 1'b0;
            level_q        <= 2'd0;
            ring_timer_q   <= 8'd0;
            hold_timer_q   <= 8'd0;
`ifdef ALARM_ESCALATE_EN
            esc_timer_q    <= 8'd0;
`endif
        end else begin
            if (enter_ring_d) begin
                state_q       <= RING;
                buzzer_q      <= 1'b1;
                stop_al_q     <= 1'b0;
                snoozing_q    <= 1'b0;
                snooze_left_q <= 8'd0;
                level_q       <= RING_ENTRY_LVL;
                ring_timer_q  <= 8'd0;
`ifdef ALARM_ESCALATE_EN
                esc_timer_q   <= 8'd0;
`endif
            end else if (enter_hold_d) begin
                state_q        <= HOLD;
                buzzer_q       <= 1'b0;
                stop_al_q      <= 1'b1;
                snoozing_q     <= 1'b0;
                snooze_left_q  <= 8'd0;
                snooze_count_q <= 3'd0;
                level_q        <= 2'd0;
                hold_timer_q   <= 8'd0;
            end else if (enter_snooze_d) begin
                state_q        <= SNOOZE;
                buzzer_q       <= 1'b0;
                stop_al_q      <= 1'b1;
                snoozing_q     <= 1'b1;
                snooze_left_q  <= SNOOZE_LEN;
                snooze_count_q <= snooze_count_q + 3'd1;
                level_q        <= 2'd0;
            end else begin
                case (state_q)
                    RING: begin
                        ring_timer_q <= ring_timer_q + 8'd1;
                        buzzer_q     <= ring_buzz_d;
                        level_q      <= ring_level_d;
`ifdef ALARM_ESCALATE_EN
                        esc_timer_q  <= (esc_timer_q == ESC_LAST) ? 8'd0 : esc_timer_q + 8'd1;
`endif
                    end
                    SNOOZE: begin
                        snooze_left_q <= snooze_left_q - 8'd1;
                    end
                    HOLD: begin
                        if (hold_timer_q == HOLD_LAST) begin
                            state_q   <= IDLE;
                            stop_al_q <= 1'b0;
                        end else begin
                            hold_timer_q <= hold_timer_q + 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // A timeout sets missed; only a stop press while idle or holding clears it.
            if (set_missed_d) begin
                missed_q <= 1'b1;
            end else if (stop_btn && (state_q == IDLE || state_q == HOLD)) begin
                missed_q <= 1'b0;
            end
        end
    end

    assign buzzer       = buzzer_q;
    assign stop_al      = stop_al_q;
    assign snoozing     = snoozing_q;
    assign snooze_left  = snooze_left_q;
    assign snooze_count = snooze_count_q;
    assign missed       = missed_q;
    assign level        = level_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_snooze_ctrl
//
// Directed scenarios for alarm_snooze_ctrl using small timer parameters.
// All outputs are packed into one vector and compared against hand-derived
// expectations. Each check is taken 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alarm_snooze_ctrl;

    localparam int RING_SEC   = 8;
    localparam int SNOOZE_SEC = 5;
    localparam int HOLD_SEC   = 4;
    localparam int MAX_SNOOZE = 2;
    localparam int ESC_STEP   = 2;

    logic       clk_1s = 1'b0;
    logic       reset;
    logic       alarm_in;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       stop_al;
    logic       snoozing;
    logic [7:0] snooze_left;
    logic [2:0] snooze_count;
    logic       missed;
    logic [1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    // {buzzer, stop_al, snoozing, missed, level[1:0], snooze_count[2:0], snooze_left[7:0]}
    logic [16:0] outs;
    logic [16:0] exp_v;
    assign outs = {buzzer, stop_al, snoozing, missed, level, snooze_count, snooze_left};

    always #5 clk_1s = ~clk_1s;

    alarm_snooze_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .HOLD_SEC  (HOLD_SEC),
        .MAX_SNOOZE(MAX_SNOOZE),
        .ESC_STEP  (ESC_STEP)
    ) dut (
        .clk_1s      (clk_1s),
        .reset       (reset),
        .alarm_in    (alarm_in),
        .stop_btn    (stop_btn),
        .snooze_btn  (snooze_btn),
        .buzzer      (buzzer),
        .stop_al     (stop_al),
        .snoozing    (snoozing),
        .snooze_left (snooze_left),
        .snooze_count(snooze_count),
        .missed      (missed),
        .level       (level)
    );

    task automatic step();
        @(posedge clk_1s);
        #1;
    endtask

    function automatic logic [16:0] ev(logic b, logic s, logic z, logic m,
                                       logic [1:0] l, logic [2:0] c, logic [7:0] n);
        return {b, s, z, m, l, c, n};
    endfunction

    // Expected buzzer in the k-th cycle of a ring period (k starts at 0).
    function automatic logic exp_buz(int k);
`ifdef ALARM_ESCALATE_EN
        if (k / ESC_STEP >= 3) return 1'b1;
`endif
        return (k % 2 == 0);
    endfunction

    // Expected volume in the k-th cycle of a ring period.
    function automatic logic [1:0] exp_lvl(int k);
`ifdef ALARM_ESCALATE_EN
        return (k / ESC_STEP >= 3) ? 2'd3 : 2'(k / ESC_STEP);
`else
        return 2'd3;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1; alarm_in = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
        step(); step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL reset_state: got %h expected %h", outs, 17'h0); end
        else $display("ok reset_state outs=%h", outs);
        reset = 1'b0;
        step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_quiet: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_quiet outs=%h", outs);
    endtask

    task automatic test_stop_in_ring();
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_v = ev(exp_buz(k), 1'b0, 1'b0, 1'b0, exp_lvl(k), 3'd0, 8'd0);
            n_checks++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL ring_cycle%0d: got %h expected %h", k, outs, exp_v); end
            else $display("ok ring_cycle%0d outs=%h", k, outs);
            if (k == 2) stop_btn = 1'b1;
            step();
        end
        stop_btn = 1'b0;
        for (int h = 0; h < HOLD_SEC; h++) begin
            exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
            n_checks++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL hold_cycle%0d: got %h expected %h", h, outs, exp_v); end
            else $display("ok hold_cycle%0d outs=%h", h, outs);
            step();
        end
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_after_stop: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_after_stop outs=%h", outs);
    endtask

    task automatic test_timeout();
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        for (int k = 0; k < RING_SEC; k++) begin
            exp_v = ev(exp_buz(k), 1'b0, 1'b0, 1'b0, exp_lvl(k), 3'd0, 8'd0);
            n_checks++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL timeout_ring%0d: got %h expected %h", k, outs, exp_v); end
            else $display("ok timeout_ring%0d outs=%h", k, outs);
            step();
        end
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL timeout_hold: got %h expected %h", outs, exp_v); end
        else $display("ok timeout_hold outs=%h", outs);
        repeat (HOLD_SEC) step();
        exp_v = ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL idle_missed_kept: got %h expected %h", outs, exp_v); end
        else $display("ok idle_missed_kept outs=%h", outs);

        // missed survives a later alarm dismissed by stop in RING
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        exp_v = ev(exp_buz(0), 1'b0, 1'b0, 1'b1, exp_lvl(0), 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL ring_missed_kept: got %h expected %h", outs, exp_v); end
        else $display("ok ring_missed_kept outs=%h", outs);
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL hold_missed_kept: got %h expected %h", outs, exp_v); end
        else $display("ok hold_missed_kept outs=%h", outs);
        repeat (HOLD_SEC) step();
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_clear_missed: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_clear_missed outs=%h", outs);

        // second timeout, then clear the flag from HOLD
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        repeat (RING_SEC) step();
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL hold_clear_missed: got %h expected %h", outs, exp_v); end
        else $display("ok hold_clear_missed outs=%h", outs);
        repeat (HOLD_SEC - 1) step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_after_hold_clear: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_after_hold_clear outs=%h", outs);
    endtask

    // Leaves the DUT in RING cycle 1 with snooze_count=1.
    task automatic test_snooze();
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        for (int j = 0; j < SNOOZE_SEC; j++) begin
            exp_v = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd1, 8'(SNOOZE_SEC - j));
            n_checks++;
            if (outs !== exp_v) begin n_fail++; $display("FAIL snooze_cycle%0d: got %h expected %h", j, outs, exp_v); end
            else $display("ok snooze_cycle%0d outs=%h", j, outs);
            step();
        end
        exp_v = ev(exp_buz(0), 1'b0, 1'b0, 1'b0, exp_lvl(0), 3'd1, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rering: got %h expected %h", outs, exp_v); end
        else $display("ok rering outs=%h", outs);
        step();
        exp_v = ev(exp_buz(1), 1'b0, 1'b0, 1'b0, exp_lvl(1), 3'd1, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rering_cycle1: got %h expected %h", outs, exp_v); end
        else $display("ok rering_cycle1 outs=%h", outs);
    endtask

    task automatic test_snooze_limit();
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        exp_v = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd2, 8'(SNOOZE_SEC));
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL snooze2_entry: got %h expected %h", outs, exp_v); end
        else $display("ok snooze2_entry outs=%h", outs);
        repeat (SNOOZE_SEC) step();
        exp_v = ev(exp_buz(0), 1'b0, 1'b0, 1'b0, exp_lvl(0), 3'd2, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rering2: got %h expected %h", outs, exp_v); end
        else $display("ok rering2 outs=%h", outs);
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL snooze3_as_stop: got %h expected %h", outs, exp_v); end
        else $display("ok snooze3_as_stop outs=%h", outs);
        repeat (HOLD_SEC) step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_after_limit: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_after_limit outs=%h", outs);
    endtask

    task automatic test_both_and_reset();
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        stop_btn = 1'b1; snooze_btn = 1'b1; step(); stop_btn = 1'b0; snooze_btn = 1'b0;
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL stop_beats_snooze: got %h expected %h", outs, exp_v); end
        else $display("ok stop_beats_snooze outs=%h", outs);
        repeat (HOLD_SEC) step();

        // stop during SNOOZE cancels it
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        step();
        exp_v = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd1, 8'(SNOOZE_SEC - 1));
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL snooze_mid: got %h expected %h", outs, exp_v); end
        else $display("ok snooze_mid outs=%h", outs);
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL snooze_cancel: got %h expected %h", outs, exp_v); end
        else $display("ok snooze_cancel outs=%h", outs);
        repeat (HOLD_SEC) step();

        // asynchronous reset in the middle of SNOOZE
        alarm_in = 1'b1; step(); alarm_in = 1'b0;
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        step(); step();
        exp_v = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd1, 8'(SNOOZE_SEC - 2));
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL before_reset: got %h expected %h", outs, exp_v); end
        else $display("ok before_reset outs=%h", outs);
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL async_reset_mid_snooze: got %h expected %h", outs, 17'h0); end
        else $display("ok async_reset_mid_snooze outs=%h", outs);
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_after_reset: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_after_reset outs=%h", outs);
    endtask

    // alarm_in held high throughout: ignored in RING/HOLD, re-arms only from IDLE.
    task automatic test_back_to_back();
        alarm_in = 1'b1; step();
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        repeat (HOLD_SEC - 1) step();
        exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL hold_ignores_alarm: got %h expected %h", outs, exp_v); end
        else $display("ok hold_ignores_alarm outs=%h", outs);
        step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL idle_gap: got %h expected %h", outs, 17'h0); end
        else $display("ok idle_gap outs=%h", outs);
        step();
        exp_v = ev(exp_buz(0), 1'b0, 1'b0, 1'b0, exp_lvl(0), 3'd0, 8'd0);
        n_checks++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rering_from_level: got %h expected %h", outs, exp_v); end
        else $display("ok rering_from_level outs=%h", outs);
        alarm_in = 1'b0;
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        repeat (HOLD_SEC) step();
        n_checks++;
        if (outs !== 17'h0) begin n_fail++; $display("FAIL final_idle: got %h expected %h", outs, 17'h0); end
        else $display("ok final_idle outs=%h", outs);
    endtask

    initial begin
        test_reset();
        test_stop_in_ring();
        test_timeout();
        test_snooze();
        test_snooze_limit();
        test_both_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
